// File: rtl/audio_ice40_fc_drain.sv
// Drains the result words latched in an FC execution-unit cascade chain, tail EU first.
// Defining FC_DRAIN_ARGMAX_EN compiles in signed argmax tracking on o_max_val/o_max_idx.
module audio_ice40_fc_drain #(
    parameter int N_EU = 8,
    parameter int IW   = 6
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_start,
    output logic          o_shift,
    input  logic [15:0]   i_cascade_in,
    output logic [15:0]   o_dout,
    output logic          o_dout_val,
    input  logic          i_dout_rdy,
    output logic [IW-1:0] o_dout_idx,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_max_val,
    output logic [IW-1:0] o_max_idx,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        SEND  = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [IW-1:0] LAST = IW'(N_EU - 1);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] k;
    logic          handshake;

    // Output handshake: a word transfers on every rising edge where o_dout_val and
    // i_dout_rdy are both high; o_dout/o_dout_idx hold steady while o_dout_val waits.
    assign handshake  = (state == SEND) && i_dout_rdy;
    assign o_dout_val = (state == SEND);
    assign o_shift    = (state == SHIFT);
    assign dbg_state  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_start) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (i_dout_rdy) state_nxt = (k == LAST) ? DONE : SHIFT;
            SHIFT:   state_nxt = LOAD;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k          <= '0;
            o_dout     <= '0;
            o_dout_idx <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_done <= (state == DONE);
            if (state == IDLE && i_start) begin
                k      <= '0;
                o_busy <= 1'b1;
            end
            if (state == DONE) begin
                o_busy <= 1'b0;
            end
            // The tail EU holds the word for index N_EU-1-k after k shifts.
            if (state == LOAD) begin
                o_dout     <= i_cascade_in;
                o_dout_idx <= LAST - k;
            end
            if (handshake && (k != LAST)) begin
                k <= k + IW'(1);
            end
        end
    end

`ifdef FC_DRAIN_ARGMAX_EN
    // Strict greater-than keeps the earlier-emitted word on ties.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_max_val <= '0;
            o_max_idx <= '0;
        end else if (handshake && ((k == '0) || ($signed(o_dout) > $signed(o_max_val)))) begin
            o_max_val <= o_dout;
            o_max_idx <= o_dout_idx;
        end
    end
`else
    assign o_max_val = '0;
    assign o_max_idx = '0;
`endif

endmodule

// File: tb/tb_audio_ice40_fc_drain.sv
// Directed bench for audio_ice40_fc_drain with a 4-EU behavioural cascade chain.
module tb_audio_ice40_fc_drain;

    localparam int N  = 4;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_start;
    logic          o_shift;
    logic [15:0]   i_cascade_in;
    logic [15:0]   o_dout;
    logic          o_dout_val;
    logic          i_dout_rdy;
    logic [IW-1:0] o_dout_idx;
    logic          o_busy;
    logic          o_done;
    logic [15:0]   o_max_val;
    logic [IW-1:0] o_max_idx;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;

    audio_ice40_fc_drain #(.N_EU(N), .IW(IW)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_start      (i_start),
        .o_shift      (o_shift),
        .i_cascade_in (i_cascade_in),
        .o_dout       (o_dout),
        .o_dout_val   (o_dout_val),
        .i_dout_rdy   (i_dout_rdy),
        .o_dout_idx   (o_dout_idx),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_max_val    (o_max_val),
        .o_max_idx    (o_max_idx),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    // Behavioural cascade chain: chain[N-1] is the tail EU feeding the drain.
    logic [15:0] chain     [N];
    logic [15:0] load_vals [N];
    logic        load_req;

    assign i_cascade_in = chain[N-1];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) chain[i] <= load_vals[i];
        end else if (o_shift) begin
            for (int i = N - 1; i > 0; i--) chain[i] <= chain[i-1];
            chain[0] <= 16'h0000;
        end
    end

    typedef struct {
        logic [3:0][15:0] d;
        int               stall_word;
        int               stall_len;
        int               start_at;
        int               post_idle;
        int               exp_cycles;
        logic [15:0]      mv;
        logic [IW-1:0]    mi;
    } vec_t;

    vec_t tbl [5];

    function automatic vec_t mk(input logic [15:0] w0, w1, w2, w3,
                                input int sw, sl, sa, pi, ec,
                                input logic [15:0] mv, input logic [IW-1:0] mi);
        vec_t v;
        v.d[0] = w0; v.d[1] = w1; v.d[2] = w2; v.d[3] = w3;
        v.stall_word = sw; v.stall_len = sl; v.start_at = sa;
        v.post_idle = pi; v.exp_cycles = ec; v.mv = mv; v.mi = mi;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic load_chain(input logic [3:0][15:0] d);
        for (int j = 0; j < N; j++) load_vals[N-1-j] = d[j];
        load_req = 1'b1;
    endtask

    task automatic run_drain(input vec_t t);
        int          cyc;
        int          words;
        int          shifts;
        int          stalled;
        int          bad;
        bit          got_done;
        logic [15:0] exp_mv;
        logic [IW-1:0] exp_mi;
`ifdef FC_DRAIN_ARGMAX_EN
        exp_mv = t.mv;
        exp_mi = t.mi;
`else
        exp_mv = 16'h0000;
        exp_mi = '0;
`endif
        cyc = 0; words = 0; shifts = 0; stalled = 0; got_done = 0;
        load_chain(t.d);
        i_start    = 1'b1;
        i_dout_rdy = 1'b1;
        while (!got_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            i_start  = 1'b0;
            load_req = 1'b0;
            if (cyc == t.start_at) i_start = 1'b1;
            if (cyc == 1) chk("busy_after_start", 32'(o_busy), 32'd1);
            if (o_shift) shifts++;
            if (o_dout_val && words < N) begin
                if (words == t.stall_word && stalled < t.stall_len) begin
                    i_dout_rdy = 1'b0;
                    stalled++;
                    chk("stall_dout_stable", 32'(o_dout), 32'(t.d[words]));
                end else begin
                    i_dout_rdy = 1'b1;
                    chk("word_value", 32'(o_dout), 32'(t.d[words]));
                    chk("word_idx", 32'(o_dout_idx), 32'(N - 1 - words));
                    words++;
                end
            end else begin
                i_dout_rdy = 1'($urandom_range(0, 1));
            end
            if (o_done) begin
                got_done = 1;
                chk("done_cycles", 32'(cyc), 32'(t.exp_cycles));
                chk("busy_at_done", 32'(o_busy), 32'd0);
            end
        end
        if (!got_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout actual=%0d cycles expected=%0d", cyc, t.exp_cycles);
        end
        chk("word_count", 32'(words), 32'(N));
        chk("shift_count", 32'(shifts), 32'(N - 1));
        chk("max_val", 32'(o_max_val), 32'(exp_mv));
        chk("max_idx", 32'(o_max_idx), 32'(exp_mi));
        if (t.post_idle != 0) begin
            bad = 0;
            for (int c = 0; c < 4; c++) begin
                @(posedge clk); #1;
                i_start = 1'b0;
                i_dout_rdy = 1'($urandom_range(0, 1));
                if (o_done || o_busy || o_shift || o_dout_val) bad++;
                if (o_max_val !== exp_mv || o_max_idx !== exp_mi) bad++;
            end
            chk("idle_after_done", 32'(bad), 32'd0);
        end
    endtask

    initial begin
        int words;
        int cyc;
        int bad;
        reset      = 1'b1;
        i_start    = 1'b0;
        i_dout_rdy = 1'b0;
        load_req   = 1'b0;
        for (int i = 0; i < N; i++) load_vals[i] = 16'h0000;

        tbl[0] = mk(16'h0010, 16'h0200, 16'h7FFF, 16'h0000, -1, 0, 0, 0, 13, 16'h7FFF, 3'd1);
        tbl[1] = mk(16'h0100, 16'h0300, 16'h0300, 16'h0050, -1, 0, 12, 1, 13, 16'h0300, 3'd2);
        tbl[2] = mk(16'h0010, 16'h0200, 16'h7FFF, 16'h0000, 1, 5, 0, 1, 18, 16'h7FFF, 3'd1);
        tbl[3] = mk(16'h8000, 16'hFFFF, 16'hFFFE, 16'h8001, -1, 0, 5, 1, 13, 16'hFFFF, 3'd2);
        tbl[4] = mk(16'h1234, 16'hABCD, 16'h0001, 16'h7000, 3, 2, 0, 1, 15, 16'h7000, 3'd0);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_shift", 32'(o_shift), 32'd0);
        chk("rst_dout", 32'(o_dout), 32'd0);
        chk("rst_val", 32'(o_dout_val), 32'd0);
        chk("rst_idx", 32'(o_dout_idx), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_max_val", 32'(o_max_val), 32'd0);
        chk("rst_max_idx", 32'(o_max_idx), 32'd0);
        chk("rst_state", 32'(dbg_state), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the cycle after the second handshake aborts the drain
        load_chain(tbl[1].d);
        i_start = 1'b1;
        i_dout_rdy = 1'b1;
        words = 0;
        cyc = 0;
        while (words < 2 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            i_start = 1'b0;
            load_req = 1'b0;
            if (o_dout_val) words++;
        end
        chk("abort_words_seen", 32'(words), 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_shift", 32'(o_shift), 32'd0);
        chk("abort_dout", 32'(o_dout), 32'd0);
        chk("abort_val", 32'(o_dout_val), 32'd0);
        chk("abort_idx", 32'(o_dout_idx), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_max_val", 32'(o_max_val), 32'd0);
        chk("abort_max_idx", 32'(o_max_idx), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            i_dout_rdy = 1'($urandom_range(0, 1));
            if (o_done || o_shift || o_dout_val || o_busy) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'd0);

        // Drains 0 and 1 run back to back: i_start one cycle after o_done
        for (int v = 0; v < 5; v++) run_drain(tbl[v]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/audio_ice40_fc_drain.md
AUDIO_ICE40_FC_DRAIN -- requirements
Module: audio_ice40_fc_drain

Interface
REQ-001 SHALL have parameter N_EU, default 8, meaning number of FC execution units in the cascade chain (2..64).
REQ-002 SHALL have parameter IW, default 6, meaning index width, with IW >= clog2(N_EU).
REQ-003 SHALL have port clk  input  1  meaning single clock; all logic is rising-edge.
REQ-004 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port i_start  input  1  meaning one-cycle pulse that starts draining results already latched in the chain.
REQ-006 SHALL have port o_shift  output  1  meaning shift enable driven to every EU's cascade-shift input.
REQ-007 SHALL have port i_cascade_in  input  16  meaning cascade output of the chain tail EU.
REQ-008 SHALL have port o_dout  output  16  meaning result word.
REQ-009 SHALL have port o_dout_val  output  1  meaning o_dout is valid.
REQ-010 SHALL have port i_dout_rdy  input  1  meaning downstream accepts the word.
REQ-011 SHALL have port o_dout_idx  output  IW  meaning EU index of o_dout.
REQ-012 SHALL have port o_busy  output  1  meaning a drain is in progress.
REQ-013 SHALL have port o_done  output  1  meaning one-cycle pulse after the last word is accepted.
REQ-014 SHALL have port o_max_val  output  16  meaning largest result of the last drain.
REQ-015 SHALL have port o_max_idx  output  IW  meaning EU index of o_max_val.

Function
REQ-016 SHALL implement a state machine with states IDLE, LOAD, SEND, SHIFT and DONE.
REQ-017 IDLE: on i_start go to LOAD, clear the word counter k, and assert o_busy from the next cycle.
REQ-018 LOAD: register i_cascade_in into o_dout, set o_dout_idx = N_EU-1-k, then go to SEND.
REQ-019 SEND: hold o_dout_val=1 with o_dout and o_dout_idx stable until i_dout_rdy=1.
REQ-020 On a SEND handshake with k < N_EU-1: increment k and go to SHIFT.
REQ-021 On a SEND handshake with k = N_EU-1: go to DONE.
REQ-022 SHIFT: assert o_shift for exactly one cycle, then go to LOAD; the tail value is sampled on the cycle after o_shift.
REQ-023 DONE: pulse o_done for one cycle, deassert o_busy and go to IDLE.
REQ-024 o_shift SHALL be asserted exactly N_EU-1 times per drain and never outside SHIFT.
REQ-025 The first word SHALL be EU N_EU-1 and the last EU 0.
REQ-026 With i_dout_rdy held high, one drain SHALL take 3*N_EU+1 cycles from i_start to o_done.
REQ-027 i_start while o_busy=1 or in DONE SHALL be ignored.
REQ-028 o_dout_val SHALL be 0 outside SEND.
REQ-029 i_dout_rdy outside SEND SHALL have no effect.

Reset
REQ-030 reset SHALL override all other inputs in the same cycle and force state IDLE and k=0.
REQ-031 Reset values SHALL be: o_shift=0, o_dout=0, o_dout_val=0, o_dout_idx=0, o_busy=0, o_done=0, o_max_val=0, o_max_idx=0.
REQ-032 Reset during a drain SHALL abort it with no o_done and no further o_shift; the chain contents are then undefined and a new FC run is required.

Configuration
REQ-033 The macro FC_DRAIN_ARGMAX_EN SHALL compile in argmax tracking.
REQ-034 With the macro: at each SEND handshake, if k=0 or o_dout > the running max (signed 16-bit compare), store the running max and index.
REQ-035 With the macro: ties SHALL keep the earlier-emitted word.
REQ-036 With the macro: o_max_val/o_max_idx SHALL update with the handshake and be final when o_done pulses.
REQ-037 With the macro: o_max_val/o_max_idx SHALL hold their value until the next drain's first handshake.
REQ-038 Without the macro: o_max_val and o_max_idx SHALL be constant 0 and the ports SHALL remain present.

Verification
REQ-039 N_EU=4, chain tail values 0x0010,0x0200,0x7FFF,0x0000, rdy=1, i_start -> words 0x0010/idx3, 0x0200/idx2, 0x7FFF/idx1, 0x0000/idx0; three o_shift pulses; o_done 13 cycles after i_start.
REQ-040 Same data, rdy low 5 cycles during the second word -> o_dout=0x0200 stable and val high throughout; no o_shift until accept; total 18 cycles.
REQ-041 i_start pulsed again mid-drain -> ignored: exactly 4 words and one o_done.
REQ-042 reset asserted in the cycle after the second handshake -> all outputs 0 next cycle; no o_done; o_shift stays 0 afterwards.
REQ-043 FC_DRAIN_ARGMAX_EN defined, values 0x0100,0x0300,0x0300,0x0050 -> o_max_val=0x0300, o_max_idx=2 at o_done; undefined -> both 0.
REQ-044 Two back-to-back drains with i_start one cycle after o_done -> second drain has correct order and counts.
